// File: rtl/layer_pkg.sv
// +--------------------------------------------------------------------------+
// | layer_pkg : widths and state encoding shared across layer output logic   |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package layer_pkg;
   localparam int PIXEL_W   = 8;
   localparam int ACC_W     = 32;
   localparam int SAT_CNT_W = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } ser_state_t;
endpackage

`default_nettype wire

// File: rtl/quantize_sat.sv
// +--------------------------------------------------------------------------+
// | quantize_sat : one lane of shift / optional round / clamp to 8 bits      |
// | Build option : CONV_SER_ROUND_EN adds round-half-up before the shift     |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module quantize_sat
   import layer_pkg::*;
#(
   parameter int SHIFT = 0
) (
   input  logic [ACC_W-1:0]   value,
   output logic [PIXEL_W-1:0] pixel,
   output logic               sat
);

   logic        [ACC_W-1:0] w_pre;
   logic signed [ACC_W-1:0] w_shifted;

`ifdef CONV_SER_ROUND_EN
   generate
      if (SHIFT > 0) begin : g_round
         assign w_pre = value + (ACC_W'(1) << (SHIFT - 1));
      end else begin : g_no_round
         assign w_pre = value;
      end
   endgenerate
`else
   assign w_pre = value;
`endif

   assign w_shifted = $signed(w_pre) >>> SHIFT;

   always_comb begin
      pixel = w_shifted[PIXEL_W-1:0];
      sat   = 1'b0;
      if (w_shifted[ACC_W-1]) begin
         pixel = '0;
         sat   = 1'b1;
      end else if (|w_shifted[ACC_W-2:PIXEL_W]) begin
         pixel = '1;
         sat   = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/conv_output_serializer.sv
// +--------------------------------------------------------------------------+
// | conv_output_serializer : quantizes NUM_TREES lanes and streams them out  |
// | Build option : CONV_SER_ROUND_EN (rounding inside quantize_sat)          |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module conv_output_serializer
   import layer_pkg::*;
#(
   parameter int NUM_TREES = 2,
   parameter int SHIFT     = 0
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [ACC_W*NUM_TREES-1:0]         pixel_out,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [PIXEL_W-1:0]                 out_pixel,
   output logic [(NUM_TREES>1 ? $clog2(NUM_TREES) : 1)-1:0] out_tree,
   output logic                               out_valid,
   input  logic                               out_ready,
   input  logic                               sat_clear,
   output logic [SAT_CNT_W-1:0]               sat_count
);

   localparam int TREE_W = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;

   ser_state_t                             r_state;
   logic [TREE_W-1:0]                      r_index;
   logic [NUM_TREES-1:0][PIXEL_W-1:0]      r_bank_pix;
   logic [NUM_TREES-1:0]                   r_bank_sat;

   logic [NUM_TREES-1:0][PIXEL_W-1:0]      w_q_pix;
   logic [NUM_TREES-1:0]                   w_q_sat;
   logic                                   w_last;
   logic                                   w_capture;
   logic                                   w_out_hs;
   logic [TREE_W-1:0]                      w_next_idx;

   generate
      for (genvar t = 0; t < NUM_TREES; t++) begin : g_lane
         quantize_sat #(
            .SHIFT (SHIFT)
         ) u_quantize_sat (
            .value (pixel_out[ACC_W*t +: ACC_W]),
            .pixel (w_q_pix[t]),
            .sat   (w_q_sat[t])
         );
      end
   endgenerate

   assign w_last     = (r_index == TREE_W'(NUM_TREES - 1));
   assign w_next_idx = r_index + TREE_W'(1);
   // Last lane can hand off to the next word in the same cycle it is accepted.
   assign in_ready   = (r_state == IDLE) || (w_last && out_ready);
   assign w_capture  = in_valid && in_ready;
   assign w_out_hs   = out_valid && out_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_index    <= '0;
         r_bank_pix <= '0;
         r_bank_sat <= '0;
         out_pixel  <= '0;
         out_tree   <= '0;
         out_valid  <= 1'b0;
         sat_count  <= '0;
      end else begin
         if (w_capture) begin
            r_state    <= EMIT;
            r_index    <= '0;
            r_bank_pix <= w_q_pix;
            r_bank_sat <= w_q_sat;
            out_pixel  <= w_q_pix[0];
            out_tree   <= '0;
            out_valid  <= 1'b1;
         end else if (r_state == EMIT && w_out_hs) begin
            if (!w_last) begin
               r_index   <= w_next_idx;
               out_pixel <= r_bank_pix[w_next_idx];
               out_tree  <= w_next_idx;
            end else begin
               r_state   <= IDLE;
               r_index   <= '0;
               out_valid <= 1'b0;
            end
         end

         if (sat_clear) begin
            sat_count <= '0;
         end else if (w_out_hs && r_bank_sat[r_index] && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_output_serializer.sv
// +--------------------------------------------------------------------------+
// | tb_conv_output_serializer : directed checks on SHIFT=0/1/2 instances     |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_conv_output_serializer;

   logic        clock;
   logic        reset;

   logic [63:0] a_pix, b_pix, c_pix;
   logic        a_in_valid, b_in_valid, c_in_valid;
   logic        a_in_ready, b_in_ready, c_in_ready;
   logic [7:0]  a_out_pixel, b_out_pixel, c_out_pixel;
   logic [0:0]  a_out_tree, b_out_tree, c_out_tree;
   logic        a_out_valid, b_out_valid, c_out_valid;
   logic        a_out_ready;
   logic        a_sat_clear;
   logic [15:0] a_sat_count, b_sat_count, c_sat_count;

   int n_checks = 0;
   int n_errors = 0;

   conv_output_serializer #(.NUM_TREES(2), .SHIFT(0)) u_dut_a (
      .clock(clock), .reset(reset), .pixel_out(a_pix), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_pixel(a_out_pixel), .out_tree(a_out_tree),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .sat_clear(a_sat_clear),
      .sat_count(a_sat_count));

   conv_output_serializer #(.NUM_TREES(2), .SHIFT(1)) u_dut_b (
      .clock(clock), .reset(reset), .pixel_out(b_pix), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_pixel(b_out_pixel), .out_tree(b_out_tree),
      .out_valid(b_out_valid), .out_ready(1'b1), .sat_clear(1'b0),
      .sat_count(b_sat_count));

   conv_output_serializer #(.NUM_TREES(2), .SHIFT(2)) u_dut_c (
      .clock(clock), .reset(reset), .pixel_out(c_pix), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .out_pixel(c_out_pixel), .out_tree(c_out_tree),
      .out_valid(c_out_valid), .out_ready(1'b1), .sat_clear(1'b0),
      .sat_count(c_sat_count));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      reset       = 1'b0;
      a_pix       = '0;  b_pix = '0;  c_pix = '0;
      a_in_valid  = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
      a_out_ready = 1'b0;
      a_sat_clear = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_valid", a_out_valid, 0);
      check("rst_pixel", a_out_pixel, 0);
      check("rst_tree",  a_out_tree,  0);
      check("rst_satcnt", a_sat_count, 0);
      reset = 1'b1;
      @(negedge clock);
      check("rst_in_ready", a_in_ready, 1);

      // {412,252}: lane0 252 unsaturated, lane1 clamps to 255
      a_pix = {32'd412, 32'd252}; a_in_valid = 1'b1; a_out_ready = 1'b1;
      @(negedge clock);
      a_in_valid = 1'b0;
      check("w1_valid", a_out_valid, 1);
      check("w1_l0_pix", a_out_pixel, 252);
      check("w1_l0_tree", a_out_tree, 0);
      check("w1_l0_inrdy", a_in_ready, 0);
      @(negedge clock);
      check("w1_l1_pix", a_out_pixel, 255);
      check("w1_l1_tree", a_out_tree, 1);
      check("w1_l1_satcnt", a_sat_count, 0);
      check("w1_l1_inrdy", a_in_ready, 1);
      @(negedge clock);
      check("w1_done_valid", a_out_valid, 0);
      check("w1_satcnt", a_sat_count, 1);

      // Negative lane clamps to 0, then a 3-cycle stall on lane 1
      a_pix = {32'd100, 32'hFFFF_FFF0}; a_in_valid = 1'b1; a_out_ready = 1'b0;
      @(negedge clock);
      a_in_valid = 1'b0;
      check("w2_l0_pix", a_out_pixel, 0);
      check("w2_l0_tree", a_out_tree, 0);
      a_out_ready = 1'b1;
      @(negedge clock);
      check("w2_satcnt", a_sat_count, 2);
      check("w2_l1_pix", a_out_pixel, 100);
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("stall_pix", a_out_pixel, 100);
         check("stall_tree", a_out_tree, 1);
         check("stall_valid", a_out_valid, 1);
         check("stall_inrdy", a_in_ready, 0);
      end
      a_out_ready = 1'b1;
      @(negedge clock);
      check("stall_resume_once", a_out_valid, 0);
      check("stall_satcnt", a_sat_count, 2);

      // sat_clear beats a simultaneous saturated handshake
      a_pix = {32'd0, 32'hFFFF_FFF0}; a_in_valid = 1'b1;
      @(negedge clock);
      a_in_valid = 1'b0; a_sat_clear = 1'b1;
      @(negedge clock);
      a_sat_clear = 1'b0;
      check("clr_satcnt", a_sat_count, 0);
      check("clr_l1_pix", a_out_pixel, 0);
      @(negedge clock);
      check("clr_satcnt_after", a_sat_count, 0);

      // Reset mid-word drops the remaining lane
      a_pix = {32'd7, 32'd5}; a_in_valid = 1'b1; a_out_ready = 1'b0;
      @(negedge clock);
      a_in_valid = 1'b0;
      check("mid_l0_pix", a_out_pixel, 5);
      #2 reset = 1'b0;
      #1 check("mid_rst_valid", a_out_valid, 0);
      @(negedge clock);
      reset = 1'b1; a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("mid_no_partial", a_out_valid, 0);
      end

      // SHIFT=1 back-to-back words: 138,226,126,206 with no bubble
      b_pix = {32'd452, 32'd276}; b_in_valid = 1'b1;
      check("b_c0_inrdy", b_in_ready, 1);
      @(negedge clock);
      b_pix = {32'd412, 32'd252};
      check("b_c1_pix", b_out_pixel, 138);
      check("b_c1_inrdy", b_in_ready, 0);
      @(negedge clock);
      check("b_c2_pix", b_out_pixel, 226);
      check("b_c2_inrdy", b_in_ready, 1);
      @(negedge clock);
      b_in_valid = 1'b0;
      check("b_c3_pix", b_out_pixel, 126);
      check("b_c3_tree", b_out_tree, 0);
      check("b_c3_inrdy", b_in_ready, 0);
      @(negedge clock);
      check("b_c4_pix", b_out_pixel, 206);
      check("b_c4_valid", b_out_valid, 1);
      @(negedge clock);
      check("b_end_valid", b_out_valid, 0);

      // SHIFT=2, 414: truncation gives 103, round-half-up gives 104
      c_pix = {32'd0, 32'd414}; c_in_valid = 1'b1;
      @(negedge clock);
      c_in_valid = 1'b0;
`ifdef CONV_SER_ROUND_EN
      check("c_round_pix", c_out_pixel, 104);
`else
      check("c_trunc_pix", c_out_pixel, 103);
`endif
      check("c_satcnt", c_sat_count, 0);
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/conv_output_serializer.md
CONV_OUTPUT_SERIALIZER -- requirements
Module: conv_output_serializer

Interface
REQ-001 Parameter NUM_TREES, default 2: number of parallel 32-bit convolution results per input word.
REQ-002 Parameter SHIFT, default 0, range 0..24: arithmetic right-shift applied before saturation.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 pixel_out  input  32*NUM_TREES  convolution results, tree t at bits [32t+31:32t], two's-complement signed.
REQ-006 in_valid  input  1  pixel_out holds a valid window result.
REQ-007 in_ready  output  1  block accepts pixel_out on this edge.
REQ-008 out_pixel  output  8  quantized unsigned pixel for next layer.
REQ-009 out_tree  output  clog2(NUM_TREES) min 1  tree index of out_pixel.
REQ-010 out_valid  output  1  out_pixel/out_tree valid.
REQ-011 out_ready  input  1  downstream accepts out_pixel on this edge.
REQ-012 sat_clear  input  1  synchronous clear of sat_count.
REQ-013 sat_count  output  16  number of emitted pixels that saturated.

Function
REQ-014 Input handshake: word captured on rising edge where in_valid && in_ready; out_valid/out_ready handshake identical.
REQ-015 States: IDLE (out_valid=0) and EMIT (out_valid=1); index register selects current lane.
REQ-016 IDLE: in_ready=1; on capture go EMIT, index=0, next cycle out_pixel=lane 0 (latency 1 cycle).
REQ-017 EMIT: on output handshake with index<NUM_TREES-1, index increments; out_pixel/out_tree update on same edge.
REQ-018 EMIT, index=NUM_TREES-1: in_ready = out_ready (combinational); output handshake plus simultaneous capture -> stay EMIT, index=0, new lane 0; output handshake without capture -> IDLE.
REQ-019 in_ready=0 in EMIT at index<NUM_TREES-1 or when out_ready=0; out_pixel/out_tree SHALL hold while out_valid && !out_ready.
REQ-020 Quantization per lane at capture: v = value >>> SHIFT (arithmetic); v<0 -> 0; v>255 -> 255; else v[7:0]; lane flagged saturated when clamped.
REQ-021 Quantized bytes and saturation flags SHALL be stored in a NUM_TREES-entry bank at capture; raw 32-bit data not retained.
REQ-022 sat_count increments by 1 on each output handshake of a saturated lane; holds at 16'hFFFF (no wrap).
REQ-023 sat_clear asserted: sat_count=0 next edge; sat_clear wins over simultaneous increment.
REQ-024 Throughput: one input word per NUM_TREES cycles when out_ready held 1; no bubble between words.

Reset
REQ-025 reset low: state IDLE, index=0, out_valid=0, out_pixel=0, out_tree=0, sat_count=0, bank cleared; in_ready=1 after release.
REQ-026 reset mid-EMIT discards remaining lanes; no partial word emitted after release.

Configuration
REQ-027 Macro CONV_SER_ROUND_EN defined: when SHIFT>0, add 2^(SHIFT-1) to value (32-bit, wrap ignored) before shift (round-half-up); saturation rules unchanged.
REQ-028 CONV_SER_ROUND_EN undefined: pure truncating arithmetic shift; no rounding adder synthesized.

Structure
REQ-029 Shared package layer_pkg holds PIXEL_W=8, ACC_W=32, SAT_CNT_W=16 and state enum {IDLE, EMIT}.
REQ-030 One sub-module quantize_sat (one lane: shift, optional round, clamp, sat flag), instantiated NUM_TREES times.

Verification
REQ-031 SHIFT=0, pixel_out={412,252}, out_ready=1 -> out_pixel 252 (tree 0, sat 0), then 255 (tree 1), sat_count=1.
REQ-032 SHIFT=1, {452,276} then {412,252} back-to-back -> stream 138,226,126,206 on 4 consecutive cycles, in_ready high on cycles 0 and 2 only.
REQ-033 SHIFT=2, lane 0 = 414: without CONV_SER_ROUND_EN -> 103; with -> 104.
REQ-034 Lane 0 = 32'hFFFFFFF0 -> out_pixel 0, sat_count+1; sat_clear with simultaneous saturated handshake -> sat_count 0.
REQ-035 out_ready held 0 for 3 cycles mid-word -> out_pixel/out_tree stable, in_ready 0; resume emits remaining lane once.
REQ-036 reset asserted while out_tree=0 in EMIT -> out_valid 0 immediately; after release no lane-1 output until new capture.
